// File: rtl/mem_pipe_pkg.sv
// Shared types for the EX->MEM control/payload pipeline stage: size encodings,
// the bundle layout with its pack/unpack helpers, and the occupancy state encoding.
package mem_pipe_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_SIZE_W = 2;
  localparam int unsigned BUNDLE_W   = 1 + MEM_SIZE_W + 1 + MEM_ADDR_W + MEM_DATA_W;

  localparam logic [MEM_SIZE_W-1:0] MEM_SZ_B = 2'b00;
  localparam logic [MEM_SIZE_W-1:0] MEM_SZ_H = 2'b01;
  localparam logic [MEM_SIZE_W-1:0] MEM_SZ_W = 2'b10;

  typedef struct packed {
    logic                  wr_en;
    logic [MEM_SIZE_W-1:0] mem_size;
    logic                  sz_ex;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } pipe_state_e;

  localparam mem_bundle_t BUNDLE_RST = '{
    wr_en:    1'b0,
    mem_size: MEM_SZ_W,
    sz_ex:    1'b0,
    addr:     '0,
    wdata:    '0
  };

  function automatic logic [BUNDLE_W-1:0] pack_bundle(input mem_bundle_t b);
    return BUNDLE_W'(b);
  endfunction

  function automatic mem_bundle_t unpack_bundle(input logic [BUNDLE_W-1:0] v);
    return mem_bundle_t'(v);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry skid holding register with a full flag; parks one bundle while
// the downstream stage stalls.
module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         full
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/mem_ctrl_pipe_stage.sv
// EX->MEM pipeline stage for the data-memory control bundle with valid/ready, stall and flush.
// Optional macro PIPE_SKID_EN selects the 2-entry skid version with a registered in_ready.
module mem_ctrl_pipe_stage
  import mem_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned SIZE_W = MEM_SIZE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_ir,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wr_en_ir_in,
  input  logic [SIZE_W-1:0] mem_size_ir_in,
  input  logic              sz_ex_ir_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wr_en_ir_out,
  output logic [SIZE_W-1:0] mem_size_ir_out,
  output logic              sz_ex_ir_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] wdata_out
);

  pipe_state_e state, state_nxt;
  mem_bundle_t in_bundle, out_q, skid_bundle;
  logic        in_xfer, out_xfer, load_out, out_from_skid;
`ifdef PIPE_SKID_EN
  logic        load_skid;
`endif

  assign in_bundle = '{
    wr_en:    wr_en_ir_in,
    mem_size: MEM_SIZE_W'(mem_size_ir_in),
    sz_ex:    sz_ex_ir_in,
    addr:     MEM_ADDR_W'(addr_in),
    wdata:    MEM_DATA_W'(wdata_in)
  };

  // Input offered during a flush is dropped even if in_ready is high
  assign out_valid = (state != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready & ~rst_ir;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (rst_ir) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_xfer) state_nxt = ST_FULL1;
        ST_FULL1: begin
`ifdef PIPE_SKID_EN
          if (in_xfer && !out_xfer) state_nxt = ST_FULL2;
`endif
          if (!in_xfer && out_xfer) state_nxt = ST_EMPTY;
        end
        ST_FULL2: if (out_xfer) state_nxt = ST_FULL1;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    load_out      = 1'b0;
    out_from_skid = 1'b0;
`ifdef PIPE_SKID_EN
    load_skid     = 1'b0;
`endif
    case (state)
      ST_EMPTY: load_out = in_xfer;
      ST_FULL1: begin
        load_out  = in_xfer & out_xfer;
`ifdef PIPE_SKID_EN
        load_skid = in_xfer & ~out_xfer;
`endif
      end
      ST_FULL2: begin
        load_out      = out_xfer;
        out_from_skid = out_xfer;
      end
      default: load_out = 1'b0;
    endcase
  end

  // Flush clears the whole output bundle so control fields are never stale
  always_ff @(posedge clk) begin
    if (rst || rst_ir) begin
      out_q <= BUNDLE_RST;
    end else if (load_out) begin
      out_q <= out_from_skid ? skid_bundle : in_bundle;
    end
  end

`ifdef PIPE_SKID_EN
  logic [BUNDLE_W-1:0] skid_q;
  logic                skid_full;

  pipe_skid_buf #(.W(BUNDLE_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clr      (rst_ir),
    .load     (load_skid),
    .drain    (out_from_skid),
    .data_in  (pack_bundle(in_bundle)),
    .data_out (skid_q),
    .full     (skid_full)
  );

  assign skid_bundle = unpack_bundle(skid_q);
  assign in_ready    = ~skid_full;
`else
  assign skid_bundle = BUNDLE_RST;
  assign in_ready    = ~out_valid | out_ready;
`endif

  assign wr_en_ir_out    = out_q.wr_en & out_valid;
  assign mem_size_ir_out = SIZE_W'(out_q.mem_size);
  assign sz_ex_ir_out    = out_q.sz_ex;
  assign addr_out        = ADDR_W'(out_q.addr);
  assign wdata_out       = DATA_W'(out_q.wdata);

endmodule

// File: tb/tb_mem_ctrl_pipe_stage.sv
// Bench for mem_ctrl_pipe_stage: directed scenarios plus random valid/ready traffic
// checked against a bounded-FIFO model (capacity 2 with PIPE_SKID_EN, else 1).
module tb_mem_ctrl_pipe_stage;
  import mem_pipe_pkg::*;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, rst_ir, in_valid, in_ready, wr_en_ir_in, sz_ex_ir_in;
  logic        out_valid, out_ready, wr_en_ir_out, sz_ex_ir_out;
  logic [1:0]  mem_size_ir_in, mem_size_ir_out;
  logic [31:0] addr_in, wdata_in, addr_out, wdata_out;

  int total = 0;
  int bad   = 0;
  mem_bundle_t q[$];

  always #5 clk = ~clk;

  mem_ctrl_pipe_stage dut (
    .clk(clk), .rst(rst), .rst_ir(rst_ir),
    .in_valid(in_valid), .in_ready(in_ready),
    .wr_en_ir_in(wr_en_ir_in), .mem_size_ir_in(mem_size_ir_in), .sz_ex_ir_in(sz_ex_ir_in),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wr_en_ir_out(wr_en_ir_out), .mem_size_ir_out(mem_size_ir_out), .sz_ex_ir_out(sz_ex_ir_out),
    .addr_out(addr_out), .wdata_out(wdata_out)
  );

  // Model: registered in_ready = room left; otherwise accept when empty or draining
  function automatic logic exp_in_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    in_valid = v; wr_en_ir_in = w; mem_size_ir_in = sz; sz_ex_ir_in = sx; addr_in = a; wdata_in = d;
  endtask

  // Advance one clock and update the model from the transfers decided this cycle
  task automatic tick();
    logic in_acc, out_acc;
    mem_bundle_t b;
    in_acc  = in_valid && exp_in_ready() && !rst && !rst_ir;
    out_acc = (q.size() > 0) && out_ready;
    b.wr_en = wr_en_ir_in; b.mem_size = mem_size_ir_in; b.sz_ex = sz_ex_ir_in;
    b.addr = addr_in; b.wdata = wdata_in;
    @(posedge clk);
    if (rst || rst_ir) q.delete();
    else begin
      if (out_acc) void'(q.pop_front());
      if (in_acc) q.push_back(b);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_ir = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, MEM_SZ_B, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (wr_en_ir_out !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%0b want=0", wr_en_ir_out); end
    total++; if (mem_size_ir_out !== 2'b10) begin bad++; $display("FAIL rst_mem_size got=%0b want=10", mem_size_ir_out); end
    total++; if (sz_ex_ir_out !== 1'b0) begin bad++; $display("FAIL rst_sz_ex got=%0b want=0", sz_ex_ir_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, 1'b1, MEM_SZ_W, 1'b0, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      else       drive(1'b0, 1'b0, MEM_SZ_B, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%0b want=1", i, in_ready); end
      if (i == 0) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_first_valid got=%0b want=0", out_valid); end
      end else begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0b want=1", i, out_valid); end
        total++; if (addr_out !== 32'h100 + 32'(4 * (i - 1))) begin bad++; $display("FAIL stream_addr[%0d] got=%0h want=%0h", i, addr_out, 32'h100 + 32'(4 * (i - 1))); end
        total++; if (wdata_out !== 32'hC0DE_0000 + 32'(i - 1)) begin bad++; $display("FAIL stream_wdata[%0d] got=%0h want=%0h", i, wdata_out, 32'hC0DE_0000 + 32'(i - 1)); end
        total++; if (wr_en_ir_out !== 1'b1) begin bad++; $display("FAIL stream_wr_en[%0d] got=%0b want=1", i, wr_en_ir_out); end
      end
      tick();
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drained got=%0b want=0", out_valid); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_addr[$];
    logic [31:0] next_addr;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, MEM_SZ_W, 1'b0, 32'h300, 32'h1);
    tick();
    exp_addr.push_back(32'h300);
    next_addr = 32'h304;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, MEM_SZ_H, 1'b1, next_addr, next_addr ^ 32'hA5A5_A5A5);
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%0b want=1", c, out_valid); end
      total++; if (addr_out !== 32'h300 || wdata_out !== 32'h1) begin bad++; $display("FAIL stall_payload[%0d] got=%0h/%0h want=300/1", c, addr_out, wdata_out); end
      total++; if (mem_size_ir_out !== MEM_SZ_W || sz_ex_ir_out !== 1'b0 || wr_en_ir_out !== 1'b1) begin bad++; $display("FAIL stall_ctrl[%0d] got=%0b/%0b/%0b want=10/0/1", c, mem_size_ir_out, sz_ex_ir_out, wr_en_ir_out); end
      total++; if (in_ready !== (c < CAP - 1)) begin bad++; $display("FAIL stall_in_ready[%0d] got=%0b want=%0b", c, in_ready, (c < CAP - 1)); end
      if (c < CAP - 1) begin exp_addr.push_back(next_addr); next_addr += 32'd4; end
      tick();
    end
    drive(1'b0, 1'b0, MEM_SZ_B, 1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    foreach (exp_addr[k]) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || addr_out !== exp_addr[k]) begin bad++; $display("FAIL stall_drain[%0d] got=%0b/%0h want=1/%0h", k, out_valid, addr_out, exp_addr[k]); end
      tick();
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup got=%0b want=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, MEM_SZ_W, 1'b0, 32'h400, 32'h4);
    tick();
`ifdef PIPE_SKID_EN
    drive(1'b1, 1'b1, MEM_SZ_W, 1'b0, 32'h404, 32'h5);
    tick();
`endif
    drive(1'b1, 1'b1, MEM_SZ_B, 1'b1, 32'h200, 32'h2);
    rst_ir = 1'b1;
    tick();
    rst_ir = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b1, MEM_SZ_B, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
    total++; if (wr_en_ir_out !== 1'b0) begin bad++; $display("FAIL flush_wr_en got=%0b want=0", wr_en_ir_out); end
    total++; if (mem_size_ir_out !== 2'b10 || sz_ex_ir_out !== 1'b0) begin bad++; $display("FAIL flush_ctrl got=%0b/%0b want=10/0", mem_size_ir_out, sz_ex_ir_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b want=1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak[%0d] got=%0b/%0h want=0", c, out_valid, addr_out); end
    end
  endtask

  task automatic test_rst_and_bubble();
    rst = 1'b1; rst_ir = 1'b1; out_ready = 1'b1;
    drive(1'b1, 1'b1, MEM_SZ_H, 1'b1, 32'h500, 32'hDEAD);
    tick();
    rst = 1'b0; rst_ir = 1'b0;
    drive(1'b0, 1'b1, MEM_SZ_H, 1'b1, 32'h508, 32'hBEEF);
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || wr_en_ir_out !== 1'b0) begin bad++; $display("FAIL both_valid_wr got=%0b/%0b want=0/0", out_valid, wr_en_ir_out); end
    total++; if (mem_size_ir_out !== 2'b10 || sz_ex_ir_out !== 1'b0) begin bad++; $display("FAIL both_ctrl got=%0b/%0b want=10/0", mem_size_ir_out, sz_ex_ir_out); end
    total++; if (addr_out !== 32'h0 || wdata_out !== 32'h0) begin bad++; $display("FAIL both_payload got=%0h/%0h want=0/0", addr_out, wdata_out); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || wr_en_ir_out !== 1'b0) begin bad++; $display("FAIL bubble_wr got=%0b/%0b want=0/0", out_valid, wr_en_ir_out); end
    drive(1'b1, 1'b1, MEM_SZ_W, 1'b0, 32'h600, 32'h6);
    tick();
    drive(1'b0, 1'b1, MEM_SZ_W, 1'b0, 32'h604, 32'h7);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || wr_en_ir_out !== 1'b1 || addr_out !== 32'h600) begin bad++; $display("FAIL store_out got=%0b/%0b/%0h want=1/1/600", out_valid, wr_en_ir_out, addr_out); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || wr_en_ir_out !== 1'b0) begin bad++; $display("FAIL bubble_after_store got=%0b/%0b want=0/0", out_valid, wr_en_ir_out); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      rst_ir    = ($urandom_range(0, 99) < 2);
      out_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), $urandom, $urandom);
      @(negedge clk);
      total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%0b want=%0b", n, out_valid, (q.size() != 0)); end
      total++; if (in_ready !== exp_in_ready()) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%0b want=%0b", n, in_ready, exp_in_ready()); end
      if (q.size() != 0) begin
        total++;
        if (addr_out !== q[0].addr || wdata_out !== q[0].wdata || mem_size_ir_out !== q[0].mem_size ||
            sz_ex_ir_out !== q[0].sz_ex || wr_en_ir_out !== q[0].wr_en) begin
          bad++;
          $display("FAIL rnd_bundle[%0d] got=%0h/%0h/%0b/%0b/%0b want=%0h/%0h/%0b/%0b/%0b", n,
                   addr_out, wdata_out, mem_size_ir_out, sz_ex_ir_out, wr_en_ir_out,
                   q[0].addr, q[0].wdata, q[0].mem_size, q[0].sz_ex, q[0].wr_en);
        end
      end else begin
        total++; if (wr_en_ir_out !== 1'b0) begin bad++; $display("FAIL rnd_bubble_wr[%0d] got=%0b want=0", n, wr_en_ir_out); end
      end
      tick();
    end
    rst_ir = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_ir = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, MEM_SZ_B, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_rst_and_bubble();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
